// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/WB/BRANCH/HALT with run control and a
// retirement counter. Optional single-step PAUSE state enabled by MC_CTRL_SINGLE_STEP_EN.
module mc_ctrl_fsm (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        run_i,
`ifdef MC_CTRL_SINGLE_STEP_EN
    input  logic        step_i,
`endif
    input  logic [5:0]  instr_op_i,
    input  logic        alu_zero_i,
    output logic        pc_write_o,
    output logic        ir_write_o,
    output logic        reg_write_o,
    output logic        reg_dst_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [2:0]  alu_op_o,
    output logic        pc_src_o,
    output logic [2:0]  state_o,
    output logic        busy_o,
    output logic        halted_o,
    output logic [31:0] retire_cnt_o
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StWb     = 3'd4,
        StBranch = 3'd5,
        StHalt   = 3'd6,
        StPause  = 3'd7
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpHalt  = 6'b111111;

    state_e      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;
    logic        retire;
    state_e      boundary_st;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= StIdle;
            op_q         <= 6'd0;
            retire_cnt_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Where a retiring state goes next.
    always_comb begin
        boundary_st = StIdle;
        if (run_i) begin
`ifdef MC_CTRL_SINGLE_STEP_EN
            boundary_st = StPause;
`else
            boundary_st = StFetch;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        retire  = 1'b0;
        unique case (state_q)
            StIdle:   if (run_i) state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: begin
                op_d = instr_op_i;
                case (instr_op_i)
                    OpRtype, OpAddi, OpSlti: state_d = StExec;
                    OpBeq:                   state_d = StBranch;
                    OpHalt:                  state_d = StHalt;
                    default: begin
                        retire  = 1'b1;
                        state_d = boundary_st;
                    end
                endcase
            end
            StExec:   state_d = StWb;
            StWb, StBranch: begin
                retire  = 1'b1;
                state_d = boundary_st;
            end
            StHalt:   if (!run_i) state_d = StIdle;
            StPause: begin
`ifdef MC_CTRL_SINGLE_STEP_EN
                if (!run_i) begin
                    state_d = StIdle;
                end else if (step_i) begin
                    state_d = StFetch;
                end
`else
                state_d = StIdle;
`endif
            end
        endcase
        retire_cnt_d = retire ? retire_cnt_q + 32'd1 : retire_cnt_q;
    end

    always_comb begin
        pc_write_o  = 1'b0;
        ir_write_o  = 1'b0;
        reg_write_o = 1'b0;
        reg_dst_o   = 1'b0;
        alu_src_a_o = 1'b0;
        alu_src_b_o = 2'b00;
        alu_op_o    = 3'b000;
        pc_src_o    = 1'b0;
        busy_o      = 1'b0;
        halted_o    = 1'b0;
        unique case (state_q)
            StIdle: ;
            StFetch: begin
                ir_write_o  = 1'b1;
                pc_write_o  = 1'b1;
                alu_src_b_o = 2'b01;
                busy_o      = 1'b1;
            end
            StDecode: begin
                alu_src_b_o = 2'b11;
                busy_o      = 1'b1;
            end
            StExec, StWb: begin
                // WB keeps the EXEC operand/op selection so the ALU result stays stable.
                alu_src_a_o = 1'b1;
                busy_o      = 1'b1;
                case (op_q)
                    OpRtype: begin
                        alu_src_b_o = 2'b00;
                        alu_op_o    = 3'b010;
                    end
                    OpAddi: begin
                        alu_src_b_o = 2'b10;
                        alu_op_o    = 3'b000;
                    end
                    OpSlti: begin
                        alu_src_b_o = 2'b10;
                        alu_op_o    = 3'b011;
                    end
                    default: ;
                endcase
                if (state_q == StWb) begin
                    reg_write_o = 1'b1;
                    reg_dst_o   = (op_q == OpRtype);
                end
            end
            StBranch: begin
                pc_write_o  = alu_zero_i;
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b00;
                alu_op_o    = 3'b001;
                pc_src_o    = 1'b1;
                busy_o      = 1'b1;
            end
            StHalt:   halted_o = 1'b1;
            StPause:  busy_o   = 1'b1;
        endcase
    end

    assign state_o      = state_q;
    assign retire_cnt_o = retire_cnt_q;

endmodule
